// File: rtl/frac_div_pkg.sv
// frac_div_pkg: shared FSM state, decimal scale and widths for the fraction divider
package frac_div_pkg;
  typedef enum logic [1:0] {IDLE, DIV, OUT} state_e;
  localparam int DEC_SCALE = 1000;
  localparam int NUM_W = 20;
  localparam int W_DEF = 10;
endpackage

// File: rtl/frac_div_seq_div_bit_step.sv
// div_bit_step: one restoring-division step
// Ports: num (partial remainder), dsh (divisor shifted to the current bit),
// qbit (quotient bit), num_nxt (remainder after the step).
module div_bit_step
  import frac_div_pkg::*;
(
  input  logic [NUM_W-1:0] num,
  input  logic [NUM_W-1:0] dsh,
  output logic             qbit,
  output logic [NUM_W-1:0] num_nxt
);
  assign qbit = num >= dsh;
  assign num_nxt = qbit ? num - dsh : num;
endmodule

// File: rtl/frac_div_seq.sv
// frac_div_seq: sequential n/d divider streaming an integer group then base-1000 fractional groups
// Ports: clk, rst (async high); start/n/d request; busy; grp/grp_valid/grp_ready/grp_last
// group stream; done and div_by_zero one-cycle completion pulses.
module frac_div_seq
  import frac_div_pkg::*;
#(
  parameter int FRAC_GROUPS = 2,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] n,
  input  logic [W-1:0] d,
  output logic         busy,
  output logic         grp_valid,
  input  logic         grp_ready,
  output logic [W-1:0] grp,
  output logic         grp_last,
  output logic         done,
  output logic         div_by_zero
);
  localparam int BW = $clog2(W);
  localparam int GW = FRAC_GROUPS > 0 ? $clog2(FRAC_GROUPS + 1) : 1;
  localparam logic [GW-1:0] GLAST = GW'(FRAC_GROUPS);
  localparam logic [BW-1:0] BTOP = BW'(W - 1);
  state_e state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d, num_step, dsh;
  logic [W-1:0] dv_q, dv_d, q_q, q_d, grp_q, grp_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [GW-1:0] gidx_q, gidx_d;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d, dz_q, dz_d, qbit;
  assign dsh = NUM_W'(dv_q) << bitcnt_q;
  div_bit_step u_step (.num(num_q), .dsh(dsh), .qbit(qbit), .num_nxt(num_step));
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    dv_d = dv_q;
    q_d = q_q;
    bitcnt_d = bitcnt_q;
    gidx_d = gidx_q;
    grp_d = grp_q;
    valid_d = valid_q;
    last_d = last_q;
    done_d = 1'b0;
    dz_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (d == '0) begin
          done_d = 1'b1;
          dz_d = 1'b1;
        end else begin
          state_d = DIV;
          num_d = NUM_W'(n);
          dv_d = d;
          q_d = '0;
          bitcnt_d = BTOP;
          gidx_d = '0;
        end
      end
      DIV: begin
        num_d = num_step;
        q_d = q_q | (W'(qbit) << bitcnt_q);
        bitcnt_d = bitcnt_q - BW'(1);
        if (bitcnt_q == '0) begin
          state_d = OUT;
          bitcnt_d = '0;
          grp_d = q_d;
          valid_d = 1'b1;
          last_d = gidx_q == GLAST;
        end
      end
      OUT: if (grp_ready) begin
        valid_d = 1'b0;
        last_d = 1'b0;
        if (last_q) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          state_d = DIV;
          // remainder < dv <= 1023, so the scaled value fits in NUM_W bits
          num_d = NUM_W'(num_q[W-1:0]) * NUM_W'(DEC_SCALE);
          q_d = '0;
          bitcnt_d = BTOP;
          gidx_d = gidx_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      num_q <= '0;
      dv_q <= '0;
      q_q <= '0;
      bitcnt_q <= '0;
      gidx_q <= '0;
      grp_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      dv_q <= dv_d;
      q_q <= q_d;
      bitcnt_q <= bitcnt_d;
      gidx_q <= gidx_d;
      grp_q <= grp_d;
      valid_q <= valid_d;
      last_q <= last_d;
      done_q <= done_d;
      dz_q <= dz_d;
    end
  end
  assign busy = state_q != IDLE;
  assign grp_valid = valid_q;
  assign grp = grp_q;
  assign grp_last = last_q;
  assign done = done_q;
  assign div_by_zero = dz_q;
endmodule
